// File: rtl/seg_status_scan.sv
// Multiplexed seven-segment driver showing a lock-status word.
// Status is committed only at frame boundaries; the error word blinks.
module seg_status_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            status,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  status_chg
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [6:0] G_I     = 7'b1001111;
  localparam logic [6:0] G_N     = 7'b1101010;
  localparam logic [6:0] G_T     = 7'b1110000;
  localparam logic [6:0] G_L     = 7'b1110001;
  localparam logic [6:0] G_O     = 7'b0000001;
  localparam logic [6:0] G_C     = 7'b0110001;
  localparam logic [6:0] G_D     = 7'b1000010;
  localparam logic [6:0] G_P     = 7'b0011000;
  localparam logic [6:0] G_E     = 7'b0110000;
  localparam logic [6:0] G_R     = 7'b1111010;
  localparam logic [6:0] G_DASH  = 7'b1111110;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  // Digit position 0 is the rightmost character of each word.
  function automatic logic [6:0] glyph(input logic [2:0] st, input int pos);
    logic [6:0] g;
    g = G_BLANK;
    if (pos < 4) begin
      case (st)
        3'd0: case (pos) 0: g = G_T; 1: g = G_I; 2: g = G_N; default: g = G_I; endcase
        3'd1: case (pos) 0: g = G_D; 1: g = G_C; 2: g = G_O; default: g = G_L; endcase
        3'd2: case (pos) 0: g = G_N; 1: g = G_E; 2: g = G_P; default: g = G_O; endcase
        3'd3: case (pos) 0: g = G_BLANK; 1: g = G_R; 2: g = G_R; default: g = G_E; endcase
        default: g = G_DASH;
      endcase
    end
    return g;
  endfunction

  logic [PW-1:0]         presc_p0;
  logic [IW-1:0]         idx_p0;
  logic [2:0]            status_q;
  logic [BW-1:0]         blink_cnt_p0;
  logic                  blink_on_p0;
  logic [6:0]            seg_p1;
  logic [NUM_DIGITS-1:0] an_p1;
  logic                  dp_p1;
  logic                  chg_p1;

  logic                  tick;
  logic                  frame;
  logic                  enter_err;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  always_comb begin
    tick      = (presc_p0 == PRE_LAST);
    frame     = tick && (idx_p0 == IDX_LAST);
    enter_err = frame && (status == 3'd3) && (status_q != 3'd3);
    an_nxt    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_nxt[i] = (idx_p0 != IW'(i));
    end
    if ((status_q == 3'd3) && !blink_on_p0) begin
      seg_nxt = G_BLANK;
    end else begin
      seg_nxt = glyph(status_q, int'(idx_p0));
    end
  end

  // Stage p0: scan, commit and blink state; stage p1: registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0     <= '0;
      idx_p0       <= '0;
      status_q     <= 3'd0;
      blink_cnt_p0 <= '0;
      blink_on_p0  <= 1'b1;
      seg_p1       <= G_BLANK;
      an_p1        <= '1;
      dp_p1        <= 1'b1;
      chg_p1       <= 1'b0;
    end else begin
      presc_p0 <= tick ? '0 : presc_p0 + PW'(1);
      if (tick) begin
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IW'(1);
      end
      chg_p1 <= 1'b0;
      if (frame) begin
        status_q <= status;
        chg_p1   <= (status != status_q);
      end
      if (enter_err) begin
        blink_cnt_p0 <= '0;
        blink_on_p0  <= 1'b1;
      end else if (blink_cnt_p0 == BLINK_LAST) begin
        blink_cnt_p0 <= '0;
        blink_on_p0  <= ~blink_on_p0;
      end else begin
        blink_cnt_p0 <= blink_cnt_p0 + BW'(1);
      end
      seg_p1 <= seg_nxt;
      an_p1  <= an_nxt;
      dp_p1  <= 1'b1;
    end
  end

  assign seg        = seg_p1;
  assign an         = an_p1;
  assign dp         = dp_p1;
  assign status_chg = chg_p1;

endmodule
